// File: rtl/pipelined_adder_tree_if.sv
// Operand/result handshake bundle for pipelined_adder_tree.
// The master drives vectors in and accepts results; the slave is the tree.
interface pipelined_adder_tree_if #(
    parameter int ELEMENTS  = 8,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8
);
    logic [ELEMENTS-1:0][IN_WIDTH-1:0] in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic signed [OUT_WIDTH-1:0]       out_data;
    logic                              out_ovf;
    logic                              out_valid;
    logic                              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ovf, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ovf, out_valid
    );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Registered signed reduction tree, one register per level, stall-all
// backpressure, and a saturating or wrapping resize after the last level.
module pipelined_adder_tree #(
    parameter int ELEMENTS  = 8,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter bit SATURATE  = 1'b1
) (
    input logic                   clk_in,
    input logic                   rst_n_in,
    pipelined_adder_tree_if.slave bus
);
    localparam int LEVELS = (ELEMENTS <= 1) ? 1 : $clog2(ELEMENTS);
    localparam int FULL_W = IN_WIDTH + LEVELS;
    localparam int CW = ((FULL_W > OUT_WIDTH) ? FULL_W : OUT_WIDTH) + 1;

    function automatic int width_at(input int k);
        int n;
        n = ELEMENTS;
        for (int i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    logic [LEVELS-1:0] v;
    logic              adv;

    assign adv          = !v[LEVELS-1] || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = v[LEVELS-1];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            v <= '0;
        end else if (adv) begin
            v <= LEVELS'({v, bus.in_valid});
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NI = width_at(k);
        localparam int NO = width_at(k + 1);

        logic signed [FULL_W-1:0] a [NI];
        logic signed [FULL_W-1:0] d [NO];
        logic signed [FULL_W-1:0] q [NO];

        if (k == 0) begin : g_src
            for (genvar i = 0; i < NI; i++) begin : g_ext
                assign a[i] = FULL_W'($signed(bus.in_data[i]));
            end
        end else begin : g_src
            for (genvar i = 0; i < NI; i++) begin : g_cp
                assign a[i] = g_lvl[k-1].q[i];
            end
        end

        // odd leftover operand rides through this level unchanged
        for (genvar i = 0; i < NO; i++) begin : g_op
            if (2 * i + 1 < NI) begin : g_add
                assign d[i] = a[2*i] + a[2*i+1];
            end else begin : g_pass
                assign d[i] = a[2*i];
            end
        end

        always_ff @(posedge clk_in) begin
            if (!rst_n_in) begin
                for (int i = 0; i < NO; i++) q[i] <= '0;
            end else if (adv) begin
                for (int i = 0; i < NO; i++) q[i] <= d[i];
            end
        end
    end

    localparam logic signed [CW-1:0] ONE  = CW'(1);
    localparam logic signed [CW-1:0] MAXV = (ONE <<< (OUT_WIDTH - 1)) - ONE;
    localparam logic signed [CW-1:0] MINV = ~MAXV;

    logic signed [CW-1:0]        sum;
    logic                        hi;
    logic                        lo;
    logic signed [OUT_WIDTH-1:0] res;

    assign sum = CW'(g_lvl[LEVELS-1].q[0]);
    assign hi  = sum > MAXV;
    assign lo  = sum < MINV;

    always_comb begin
        res = sum[OUT_WIDTH-1:0];
        if (SATURATE && hi) begin
            res = MAXV[OUT_WIDTH-1:0];
        end else if (SATURATE && lo) begin
            res = MINV[OUT_WIDTH-1:0];
        end
    end

    assign bus.out_data = res;
    assign bus.out_ovf  = hi || lo;
endmodule
